// File: rtl/fifo_pkt_reader_pkg.sv
// ============================================================================
// Module      : fifo_pkt_reader_pkg
// Description : Shared types and default constants for the FIFO packet reader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkt_reader_pkg;

    localparam int c_DEF_WIDTH       = 9;
    localparam int c_DEF_MAX_PKT_LEN = 256;
    localparam int c_DEF_LEN_WIDTH   = 9;
    localparam int c_FLAG_BIT        = c_DEF_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_SOP     = 2'd0,
        ST_BODY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_pkt_skid2.sv
// ============================================================================
// Module      : fifo_pkt_skid2
// Description : Two-entry {data,last} skid buffer; the head entry drives the
//               registered valid/ready output stream.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_pkt_skid2 #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_head_data;
    logic [DW-1:0] r_tail_data;
    logic          r_head_last;
    logic          r_tail_last;
    logic          r_valid;
    logic [1:0]    r_count;
    logic          w_pop;

    assign w_pop = r_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head_data <= '0;
            r_tail_data <= '0;
            r_head_last <= 1'b0;
            r_tail_last <= 1'b0;
            r_valid     <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head_data <= i_data;
                        r_head_last <= i_last;
                        r_valid     <= 1'b1;
                        r_count     <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, w_pop})
                        2'b11: begin
                            r_head_data <= i_data;
                            r_head_last <= i_last;
                        end
                        2'b10: begin
                            r_tail_data <= i_data;
                            r_tail_last <= i_last;
                            r_count     <= 2'd2;
                        end
                        2'b01: begin
                            r_valid <= 1'b0;
                            r_count <= 2'd0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    // The reader never pushes while full, so only a pop matters here.
                    if (w_pop) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_count     <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_data  = r_head_data;
    assign o_last  = r_head_last;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_pkt_reader.sv
// ============================================================================
// Module      : fifo_pkt_reader
// Description : Pops a FWFT FIFO, splits payload/EOP flag, enforces a maximum
//               packet length. Optional stats: FIFO_PKT_READER_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_pkt_reader
    import fifo_pkt_reader_pkg::*;
#(
    parameter int WIDTH       = c_DEF_WIDTH,
    parameter int MAX_PKT_LEN = c_DEF_MAX_PKT_LEN,
    parameter int LEN_WIDTH   = c_DEF_LEN_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [WIDTH-1:0]     i_fifo_dout,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_read,
    output logic [WIDTH-2:0]     o_out_data,
    output logic                 o_out_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [LEN_WIDTH-1:0] o_pkt_len,
    output logic                 o_pkt_done,
    output logic                 o_over_len,
    output logic                 o_idle,
    output logic [15:0]          o_pkt_count,
    output logic [15:0]          o_drop_count
);

    localparam int                   c_FLAG      = WIDTH - 1;
    localparam logic [LEN_WIDTH-1:0] c_TRUNC_CNT = LEN_WIDTH'(MAX_PKT_LEN - 1);

    state_t               r_state;
    logic [LEN_WIDTH-1:0] r_in_cnt;
    logic [LEN_WIDTH-1:0] r_out_cnt;
    logic [LEN_WIDTH-1:0] r_pkt_len;
    logic                 r_pkt_done;
    logic                 r_over_len;

    logic                 w_pop;
    logic                 w_store;
    logic                 w_flag;
    logic                 w_trunc;
    logic                 w_hs;
    logic [1:0]           w_skid_count;

    assign w_flag  = i_fifo_dout[c_FLAG];
    assign w_pop   = !i_reset && !i_fifo_empty &&
                     ((r_state == ST_DISCARD) || (w_skid_count < 2'd2));
    assign w_store = w_pop && (r_state != ST_DISCARD);
    // The MAX_PKT_LEN-th byte without an EOP flag closes the packet early.
    assign w_trunc = w_store && (r_state == ST_BODY) && !w_flag && (r_in_cnt == c_TRUNC_CNT);
    assign w_hs    = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_SOP;
            r_in_cnt   <= '0;
            r_over_len <= 1'b0;
        end else begin
            r_over_len <= w_trunc;
            if (w_pop) begin
                case (r_state)
                    ST_SOP: begin
                        if (!w_flag) begin
                            r_in_cnt <= LEN_WIDTH'(1);
                            r_state  <= ST_BODY;
                        end
                    end
                    ST_BODY: begin
                        if (w_flag || w_trunc) begin
                            r_in_cnt <= '0;
                            r_state  <= w_flag ? ST_SOP : ST_DISCARD;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (w_flag) begin
                            r_state <= ST_SOP;
                        end
                    end
                    default: r_state <= ST_SOP;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_cnt  <= '0;
            r_pkt_len  <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= w_hs && o_out_last;
            if (w_hs) begin
                if (o_out_last) begin
                    r_pkt_len <= r_out_cnt + 1'b1;
                    r_out_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end
        end
    end

    fifo_pkt_skid2 #(
        .DW (WIDTH - 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_store),
        .i_data  (i_fifo_dout[c_FLAG-1:0]),
        .i_last  (w_flag || w_trunc),
        .i_ready (i_out_ready),
        .o_data  (o_out_data),
        .o_last  (o_out_last),
        .o_valid (o_out_valid),
        .o_count (w_skid_count)
    );

`ifdef FIFO_PKT_READER_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_hs && o_out_last) begin
                r_pkt_count <= sat_inc16(r_pkt_count);
            end
            if (w_pop && (r_state == ST_DISCARD)) begin
                r_drop_count <= sat_inc16(r_drop_count);
            end
        end
    end

    assign o_pkt_count  = r_pkt_count;
    assign o_drop_count = r_drop_count;
`else
    assign o_pkt_count  = 16'd0;
    assign o_drop_count = 16'd0;
`endif

    assign o_fifo_read = w_pop;
    assign o_pkt_len   = r_pkt_len;
    assign o_pkt_done  = r_pkt_done;
    assign o_over_len  = r_over_len;
    assign o_idle      = (r_state == ST_SOP) && (w_skid_count == 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
// ============================================================================
// Module      : tb_fifo_pkt_reader
// Description : Randomized self-checking bench for fifo_pkt_reader against a
//               queue-based packet model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_pkt_reader;

    localparam int c_MAXL = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [8:0]  i_fifo_dout;
    logic        i_fifo_empty;
    logic        o_fifo_read;
    logic [7:0]  o_out_data;
    logic        o_out_last;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [8:0]  o_pkt_len;
    logic        o_pkt_done;
    logic        o_over_len;
    logic        o_idle;
    logic [15:0] o_pkt_count;
    logic [15:0] o_drop_count;

    always #5 clk = ~clk;

    fifo_pkt_reader #(
        .WIDTH       (9),
        .MAX_PKT_LEN (c_MAXL),
        .LEN_WIDTH   (9)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_dout  (i_fifo_dout),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_read  (o_fifo_read),
        .o_out_data   (o_out_data),
        .o_out_last   (o_out_last),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_pkt_len    (o_pkt_len),
        .o_pkt_done   (o_pkt_done),
        .o_over_len   (o_over_len),
        .o_idle       (o_idle),
        .o_pkt_count  (o_pkt_count),
        .o_drop_count (o_drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: source FIFO contents, bytes owed downstream, packet bookkeeping.
    logic [8:0] src_q[$];
    logic [8:0] exp_q[$];
    int  m_in_cnt   = 0;
    bit  m_disc     = 1'b0;
    int  m_out_cnt  = 0;
    int  m_pkt_len  = 0;
    int  m_pkt_cnt  = 0;
    int  m_drop_cnt = 0;
    bit  exp_done   = 1'b0;
    bit  exp_over   = 1'b0;
    int  tcnt       = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_in_cnt   = 0;
        m_disc     = 1'b0;
        m_out_cnt  = 0;
        m_pkt_len  = 0;
        m_pkt_cnt  = 0;
        m_drop_cnt = 0;
    endtask

    task automatic model_pop(input logic [8:0] w);
        logic last;
        if (m_disc) begin
            if (m_drop_cnt < 16'hFFFF) m_drop_cnt++;
            if (w[8]) m_disc = 1'b0;
        end else begin
            last = w[8];
            if (!w[8]) begin
                m_in_cnt++;
                if (m_in_cnt == c_MAXL) begin
                    last     = 1'b1;
                    exp_over = 1'b1;
                    m_disc   = 1'b1;
                    m_in_cnt = 0;
                end
            end else begin
                m_in_cnt = 0;
            end
            exp_q.push_back({last, w[7:0]});
        end
    endtask

    // One clock: rmode 0=random ready, 1=always ready, 2=pattern 1,0,0,1.
    task automatic step(input int rmode, input bit gaps, input bit rst);
        bit hs, rd, exp_rd, gap;
        logic [8:0] b, w;
        i_reset = rst;
        case (rmode)
            0:       i_out_ready = 1'($urandom_range(0, 1));
            1:       i_out_ready = 1'b1;
            default: i_out_ready = ((tcnt % 4) == 0) || ((tcnt % 4) == 3);
        endcase
        tcnt++;
        gap          = gaps && ($urandom_range(0, 3) == 0);
        i_fifo_empty = (src_q.size() == 0) || gap;
        i_fifo_dout  = (src_q.size() != 0) ? src_q[0] : 9'($urandom);
        #1;
        hs     = o_out_valid && i_out_ready;
        rd     = o_fifo_read;
        w      = i_fifo_dout;
        exp_rd = !rst && !i_fifo_empty && (m_disc || (exp_q.size() < 2));
        check_eq("fifo_read", 32'(rd), 32'(exp_rd));
        @(posedge clk);
        exp_done = 1'b0;
        exp_over = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (hs && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                m_out_cnt++;
                if (b[8]) begin
                    exp_done  = 1'b1;
                    m_pkt_len = m_out_cnt;
                    m_out_cnt = 0;
                    if (m_pkt_cnt < 16'hFFFF) m_pkt_cnt++;
                end
            end
            if (rd && src_q.size() != 0) begin
                void'(src_q.pop_front());
                model_pop(w);
            end
        end
        #1;
        check_eq("out_valid", 32'(o_out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            b = exp_q[0];
            check_eq("out_data", 32'(o_out_data), 32'(b[7:0]));
            check_eq("out_last", 32'(o_out_last), 32'(b[8]));
        end
        check_eq("pkt_done", 32'(o_pkt_done), 32'(exp_done));
        check_eq("pkt_len", 32'(o_pkt_len), 32'(m_pkt_len));
        check_eq("over_len", 32'(o_over_len), 32'(exp_over));
        check_eq("idle", 32'(o_idle), 32'(m_in_cnt == 0 && !m_disc && exp_q.size() == 0));
`ifdef FIFO_PKT_READER_STATS_EN
        check_eq("pkt_count", 32'(o_pkt_count), 32'(m_pkt_cnt));
        check_eq("drop_count", 32'(o_drop_count), 32'(m_drop_cnt));
`else
        check_eq("pkt_count", 32'(o_pkt_count), 32'd0);
        check_eq("drop_count", 32'(o_drop_count), 32'd0);
`endif
    endtask

    task automatic drain(input int rmode, input bit gaps);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || m_disc || m_in_cnt != 0) && n < 2000) begin
            step(rmode, gaps, 1'b0);
            n++;
        end
        if (n >= 2000) check_eq("drain_timeout", 32'(exp_q.size() + src_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) step(rmode, gaps, 1'b0);
    endtask

    task automatic push_pkt(input int len);
        for (int i = 0; i < len; i++)
            src_q.push_back({(i == len - 1), 8'($urandom)});
    endtask

    initial begin
        int n;
        i_reset      = 1'b1;
        i_out_ready  = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_dout  = '0;
        @(posedge clk);
        #1;

        // Reset held with data waiting: no pops, outputs at reset values.
        src_q.push_back(9'h011);
        src_q.push_back(9'h022);
        src_q.push_back(9'h133);
        for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b1);
        drain(1, 1'b0);

        // Same packet under a stalling ready pattern.
        src_q.push_back(9'h011);
        src_q.push_back(9'h022);
        src_q.push_back(9'h133);
        tcnt = 0;
        drain(2, 1'b0);

        // Over-length packet followed by two single-byte packets.
        for (int i = 1; i <= 5; i++) src_q.push_back(9'(i));
        src_q.push_back(9'h106);
        src_q.push_back(9'h1AA);
        src_q.push_back(9'h1BB);
        drain(1, 1'b0);

        // Random packets, random backpressure and FIFO gaps.
        for (int p = 0; p < 40; p++) push_pkt($urandom_range(1, 7));
        drain(0, 1'b1);
        for (int p = 0; p < 20; p++) push_pkt($urandom_range(1, 7));
        drain(1, 1'b1);

        // Reset after two bytes of an unfinished packet have been delivered.
        src_q.push_back(9'h041);
        src_q.push_back(9'h042);
        src_q.push_back(9'h043);
        n = 0;
        while (m_out_cnt < 2 && n < 50) begin
            step(1, 1'b0, 1'b0);
            n++;
        end
        if (n >= 50) check_eq("midpkt_timeout", 32'(m_out_cnt), 32'd2);
        src_q.delete();
        for (int i = 0; i < 2; i++) step(1, 1'b0, 1'b1);
        src_q.push_back(9'h051);
        src_q.push_back(9'h152);
        drain(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Read-side consumer for the 512x9 first-word-fall-through FIFO, running in that FIFO's read clock domain.
- Pops 9-bit words and splits each into an 8-bit payload (bits 7:0) and an end-of-packet flag (bit 8).
- Presents the payload downstream as a valid/ready byte stream with a last marker, via a 2-entry skid buffer.
- Enforces a maximum packet length and reports per-packet length.

Parameters:
- Width, 9, FIFO word width; the top bit is the end-of-packet flag, the rest is payload.
- MaxPktLen, 256, maximum bytes delivered per packet; range 2..2^LenWidth-1.
- LenWidth, 9, width of the length counters and of PktLen.

Ports:
- Clk  in  1  single clock; same as the FIFO read clock.
- Reset  in  1  synchronous, active-high.
- FifoDout  in  Width  FWFT data; valid whenever FifoEmpty=0.
- FifoEmpty  in  1  FIFO empty.
- FifoRead  out  1  pop strobe to the FIFO read enable; combinational.
- OutData  out  Width-1  payload byte.
- OutLast  out  1  last byte of packet.
- OutValid  out  1  output word valid.
- OutReady  in  1  downstream accept.
- PktLen  out  LenWidth  byte count of the most recently completed packet.
- PktDone  out  1  one-cycle pulse when a last byte handshakes.
- OverLen  out  1  one-cycle pulse when a packet is truncated.
- Idle  out  1  state SOP and skid empty.

Behaviour:
- Reset values: OutValid=0, OutData=0, OutLast=0, PktLen=0, PktDone=0, OverLen=0, Idle=1, skid empty, state=SOP, counters 0.
- FifoRead is 0 while Reset=1.
- Reset mid-packet: skid contents and any partial packet are discarded; no PktDone is issued.
- Handshake:
  - A byte transfers when OutValid&&OutReady.
  - OutData/OutLast are held stable while OutValid=1 and OutReady=0.
- Pop rule: FifoRead = !FifoEmpty && (state==DISCARD || SkidCount<2), where SkidCount counts occupied entries (0..2).
- Latency: a word popped in cycle N appears on OutValid in cycle N+1 if the skid is empty.
- Throughput: sustained 1 byte/cycle with OutReady held high (SkidCount steady at 1).
- Intake counter InCnt counts words stored into the skid for the current packet.
- States:
  - SOP: no bytes of the current packet stored yet.
    - Storing a word with flag=0 sets InCnt=1 and moves to BODY.
    - Storing a word with flag=1 (a 1-byte packet) stays in SOP.
  - BODY: each stored word increments InCnt.
    - Word with flag=1: store with last=1, InCnt=0, go to SOP.
    - Word with flag=0 and InCnt==MaxPktLen-1: store with last forced to 1, pulse OverLen next cycle, go to DISCARD.
  - DISCARD: pop without storing while FifoEmpty=0.
    - Popping a word with flag=1 goes to SOP.
    - OutValid is unaffected by discarding; already stored bytes still drain.
- Output counter OutCnt counts handshaked bytes.
  - On a handshake with OutLast=1: PktLen <= OutCnt+1, PktDone=1 for one cycle, OutCnt <= 0.
  - A truncated packet reports PktLen=MaxPktLen.
- Simultaneous push and pop on the skid in the same cycle leaves SkidCount unchanged; order is preserved.
- FifoEmpty rising mid-packet: stall with no timeout; state is held.

Optional Feature:
- Macro: FIFO_PKT_READER_STATS_EN.
- When defined: adds output ports PktCount[15:0] and DropCount[15:0].
  - Both saturate at 0xFFFF and clear on Reset.
  - PktCount increments on each PktDone.
  - DropCount increments per word popped in DISCARD.
- When undefined: ports are still present, tied to 0, no counter logic is generated, and the port list is identical in both builds.

Decomposition:
- Package fifo_pkt_reader_pkg:
  - state enum {SOP, BODY, DISCARD}
  - FLAG_BIT = Width-1
  - default MaxPktLen and LenWidth constants
- Sub-module fifo_pkt_skid2: 2-entry {data,last} skid buffer with push/pop, SkidCount and valid; holds all output registers.

Test Plan:
- Reset while FifoEmpty=0 -> FifoRead=0, OutValid=0, Idle=1. After release, the first pop follows on the next cycle.
- Packet 0x11,0x22,0x133 (flag on 3rd word) with OutReady=1 -> bytes 11,22,33 on consecutive cycles, OutLast only on 33, PktDone pulse, PktLen=3.
- Same 3-word packet with OutReady toggled 1,0,0,1,... -> no byte lost or duplicated, data stable while stalled, FifoRead=0 whenever SkidCount=2.
- MaxPktLen=4, 6-word packet ending with flag -> 4 bytes output, last forced on byte 4, OverLen pulse, 2 words dropped, PktLen=4, next packet starts clean.
- Single-word packet 0x1AA followed immediately by 0x1BB -> two 1-byte packets, two PktDone pulses, PktLen=1 each time.
- Reset asserted mid-packet after 2 bytes delivered -> skid cleared, no PktDone. With FIFO_PKT_READER_STATS_EN defined, PktCount=0 after reset.
